panel_input_conditioner: RTL
============================

// Module: panel_input_conditioner
// PURPOSE
//  Board-side input path for the single-step CPU demo; the display mux drives the panel, this block reads it.
//  Synchronises and debounces the Button push-button and SW select switches.
//  Outputs a clean single-step clock (step_clk) for the CPU and a stable switch code for the display mux.
//  Sits between the Basys3 pins and the CPU top / display logic, in the 100 MHz CLK domain.
// PARAMETERS
//  DEBOUNCE_CYCLES   1000000  consecutive stable samples needed to accept a level change (10 ms @100 MHz)
//  STEP_HIGH_CYCLES  50000    step_clk high time; also the minimum low (guard) time after each step
//  SW_W              2        width of the switch select vector
// PORTS
//  CLK         in   1     system clock, all logic on posedge
//  Reset       in   1     asynchronous, active-high reset
//  Button      in   1     raw step push-button (asynchronous, bouncy)
//  SW          in   SW_W  raw select switches (asynchronous, bouncy)
//  btn_level   out  1     debounced button level
//  step_pulse  out  1     one-CLK pulse per accepted press
//  step_clk    out  1     stretched step clock to the CPU
//  sw_sel      out  SW_W  debounced switch code
//  sw_changed  out  1     one-CLK pulse when sw_sel updates
// BEHAVIOUR
//  Reset (async, any time, including mid-operation): all outputs 0; sync FFs 0; counters 0; FSMs at initial state.
//  Sync: 2-FF synchroniser per input bit. Edge n samples raw; sync value valid after edge n+1.
//  Button debounce FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
//   - In STABLE_x, a synced value != x -> WAIT_*; counter cleared.
//   - In WAIT_*, each matching sample increments the counter. Any mismatch -> back to STABLE_x, counter cleared.
//   - Counter reaching DEBOUNCE_CYCLES -> STABLE_other; btn_level updates on that edge.
//   - Latency: btn_level rises DEBOUNCE_CYCLES+2 edges after the first edge sampling Button=1 (held steady).
//  step_pulse: high for exactly one cycle on the edge btn_level goes 0->1, only if the step FSM is S_LOW.
//   - Otherwise the press is dropped. No queueing.
//   - Release (1->0) never produces a pulse.
//  Step FSM: S_LOW, S_HIGH, S_GUARD.
//   - S_LOW + step_pulse -> S_HIGH; step_clk=1 from the next edge.
//   - S_HIGH: step_clk=1 for exactly STEP_HIGH_CYCLES cycles -> S_GUARD.
//   - S_GUARD: step_clk=0 for STEP_HIGH_CYCLES cycles -> S_LOW.
//  SW debounce: one shared counter for the whole vector.
//   - synced != sw_sel starts the count.
//   - A change of the synced vector during the count restarts it at 0 with the new candidate.
//   - Return to synced == sw_sel aborts the count.
//   - Count reaching DEBOUNCE_CYCLES: sw_sel <= candidate and sw_changed = 1 on the same edge.
//  Simultaneous button and SW events are independent; no interaction.
//  Counter widths: $clog2(max(DEBOUNCE_CYCLES, STEP_HIGH_CYCLES)+1). Counters saturate, never wrap.
//  Reset released with Button held -> treated as a fresh press: exactly one step after DEBOUNCE_CYCLES+2 edges.
// STRUCTURE
//  Shared package panel_pkg:
//   - debounce state encodings (STABLE_LO=2'd0, WAIT_HI=2'd1, STABLE_HI=2'd2, WAIT_LO=2'd3)
//   - step state encodings (S_LOW, S_HIGH, S_GUARD)
//   - default timing constants
//  Sub-module debounce_cell #(W, CYCLES): 2-FF sync + debounce for a W-bit vector.
//   - Outputs: level[W-1:0], update pulse.
//   - Instantiated with W=1 for Button and W=SW_W for SW.
//  Top holds the step FSM and the step_pulse edge logic.
// TESTING (bench uses DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=3; edge 0 = first edge sampling the new value)
//  1 Clean press: Button 0->1 held 20 cycles -> btn_level=1 and step_pulse=1 after edge 6 (one cycle only);
//    step_clk=1 after edges 7..9, 0 from edge 10.
//  2 Bounce: Button pattern 1,1,1,0 repeated 5x -> no step_pulse, btn_level stays 0;
//    then held 1 -> exactly one pulse 6 edges after the last 0->1.
//  3 Re-press in guard: second press accepted while step FSM is S_HIGH/S_GUARD -> no second step_clk;
//    a press accepted in S_LOW afterwards -> step_clk high for 3 cycles.
//  4 SW: 00->10 held -> sw_sel=10 and sw_changed=1 after edge 6; a 1-cycle SW glitch 10->11->10 -> no change, no pulse.
//  5 Reset mid-step: assert Reset while step_clk=1 and sw_sel=10 -> step_clk=0, sw_sel=00 immediately (async);
//    release with Button held -> one step_pulse 6 edges later.
//  6 Release: Button 1->0 after an accepted press -> btn_level falls after edge 6, step_pulse stays 0.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared encodings and default timing for the panel input path.
package panel_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  typedef enum logic [1:0] {
    S_LOW   = 2'd0,
    S_HIGH  = 2'd1,
    S_GUARD = 2'd2
  } step_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1000000;
  localparam int unsigned DEF_STEP_HIGH_CYCLES = 50000;
  localparam int unsigned DEF_SW_W             = 2;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/panel_input_conditioner_debounce_cell.sv
// Two-flop synchroniser followed by a counting debouncer for a W-bit input vector.
module debounce_cell
  import panel_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W  = cnt_width(CYCLES, CYCLES)
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level,
  output logic         update
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [W-1:0]     sync1, sync2, cand, cand_nxt, level_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             update_nxt;
  db_state_t        state, state_nxt;

  // For W>1 the LO/HI half of the state name follows bit 0 only; a new
  // candidate vector during a wait restarts the count in the same wait state.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    level_nxt  = level;
    update_nxt = 1'b0;
    case (state)
      STABLE_LO, STABLE_HI: begin
        if (sync2 != level) begin
          state_nxt = level[0] ? WAIT_LO : WAIT_HI;
          cand_nxt  = sync2;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (sync2 == level) begin
          state_nxt = level[0] ? STABLE_HI : STABLE_LO;
          cnt_nxt   = '0;
        end else if (sync2 != cand) begin
          cand_nxt = sync2;
          cnt_nxt  = '0;
        end else if (cnt == LAST) begin
          state_nxt  = cand[0] ? STABLE_HI : STABLE_LO;
          level_nxt  = cand;
          update_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      level  <= '0;
      update <= 1'b0;
      cnt    <= '0;
      state  <= STABLE_LO;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      cand   <= cand_nxt;
      level  <= level_nxt;
      update <= update_nxt;
      cnt    <= cnt_nxt;
      state  <= state_nxt;
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// Button/switch conditioning for the single-step CPU demo: debounced levels,
// one step pulse per accepted press and a stretched, guarded step clock.
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STEP_HIGH_CYCLES = DEF_STEP_HIGH_CYCLES,
  parameter int unsigned SW_W             = DEF_SW_W
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Button,
  input  logic [SW_W-1:0] SW,
  output logic            btn_level,
  output logic            step_pulse,
  output logic            step_clk,
  output logic [SW_W-1:0] sw_sel,
  output logic            sw_changed
);

  localparam int unsigned      CNT_W     = cnt_width(DEBOUNCE_CYCLES, STEP_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_HIGH_CYCLES - 1);

  logic             btn_upd;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  step_state_t      step_state, step_nxt;

  debounce_cell #(.W(1), .CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
    .CLK    (CLK),
    .Reset  (Reset),
    .raw    (Button),
    .level  (btn_level),
    .update (btn_upd)
  );

  debounce_cell #(.W(SW_W), .CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw (
    .CLK    (CLK),
    .Reset  (Reset),
    .raw    (SW),
    .level  (sw_sel),
    .update (sw_changed)
  );

  // Presses landing outside S_LOW are dropped, not queued.
  always_comb begin
    step_pulse = btn_upd & btn_level & (step_state == S_LOW);
  end

  always_comb begin
    step_nxt     = step_state;
    step_cnt_nxt = step_cnt;
    case (step_state)
      S_LOW: begin
        if (step_pulse) begin
          step_nxt     = S_HIGH;
          step_cnt_nxt = '0;
        end
      end
      S_HIGH, S_GUARD: begin
        if (step_cnt == STEP_LAST) begin
          step_nxt     = (step_state == S_HIGH) ? S_GUARD : S_LOW;
          step_cnt_nxt = '0;
        end else if (step_cnt != '1) begin
          step_cnt_nxt = step_cnt + 1'b1;
        end
      end
      default: begin
        step_nxt     = S_LOW;
        step_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      step_state <= S_LOW;
      step_cnt   <= '0;
      step_clk   <= 1'b0;
    end else begin
      step_state <= step_nxt;
      step_cnt   <= step_cnt_nxt;
      step_clk   <= (step_nxt == S_HIGH);
    end
  end

endmodule
